// File: rtl/pipeline_stall_controller.sv
// Freeze/bubble/flush control for the 5-stage pipeline registers, with
// saturating stall/flush/mem-wait statistics and sticky protocol/timeout flags.
module pipeline_stall_controller #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_back,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic             mem_timeout,
    output logic             hazard_err
);

    localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   memwait_cnt_q, memwait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               hazard_err_q, hazard_err_d;

    logic case_mem, case_br, case_hz;

    // Priority decode: mem_busy > branch_taken > hazard_detected
    assign case_mem = mem_busy;
    assign case_br  = !mem_busy && branch_taken;
    assign case_hz  = !mem_busy && !branch_taken && hazard_detected;

    // Mealy controls, forced low while reset is held
    always_comb begin
        freeze_pc    = rst_n && (case_mem || case_hz);
        freeze_if_id = rst_n && (case_mem || case_hz);
        bubble_id_ex = rst_n && (case_br || case_hz);
        flush_if_id  = rst_n && case_br;
        freeze_back  = rst_n && case_mem;
    end

    // Next-state for FSM, wait timer, counters and sticky flags
    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        memwait_cnt_d = memwait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        hazard_err_d  = hazard_err_q;

        unique case (state_q)
            RUN: begin
                if (case_mem)     state_d = MEM_WAIT;
                else if (case_hz) state_d = LOAD_STALL;
            end
            LOAD_STALL: begin
                if (case_mem) begin
                    state_d = MEM_WAIT;
                end else if (case_hz) begin
                    state_d      = LOAD_STALL;
                    hazard_err_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (mem_busy) begin
            if (timer_q == TMR_W'(MEM_TIMEOUT)) timer_d = timer_q;
            else                                timer_d = timer_q + TMR_W'(1);
        end
        if (timer_d == TMR_W'(MEM_TIMEOUT)) mem_timeout_d = 1'b1;

        if (cnt_clr) begin
            stall_cnt_d   = '0;
            flush_cnt_d   = '0;
            memwait_cnt_d = '0;
        end else begin
            if (case_hz  && stall_cnt_q   != '1) stall_cnt_d   = stall_cnt_q   + CNT_W'(1);
            if (case_br  && flush_cnt_q   != '1) flush_cnt_d   = flush_cnt_q   + CNT_W'(1);
            if (case_mem && memwait_cnt_q != '1) memwait_cnt_d = memwait_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            timer_q       <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
            mem_timeout_q <= 1'b0;
            hazard_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            memwait_cnt_q <= memwait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            hazard_err_q  <= hazard_err_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign memwait_cnt = memwait_cnt_q;
    assign mem_timeout = mem_timeout_q;
    assign hazard_err  = hazard_err_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: a wide-counter instance plus a
// 2-bit-counter instance driven by the same stimulus for saturation.
module tb_pipeline_stall_controller;

    logic clk, rst_n;
    logic hazard_detected, branch_taken, mem_busy, cnt_clr;

    logic        freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back;
    logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
    logic        mem_timeout, hazard_err;

    logic        s_freeze_pc, s_freeze_if_id, s_bubble_id_ex, s_flush_if_id, s_freeze_back;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_memwait_cnt;
    logic        s_mem_timeout, s_hazard_err;

    logic [4:0]  ctl;
    assign ctl = {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back};

    int errors = 0;
    int checks = 0;

    pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .freeze_back(freeze_back),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt),
        .mem_timeout(mem_timeout), .hazard_err(hazard_err)
    );

    pipeline_stall_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id),
        .bubble_id_ex(s_bubble_id_ex), .flush_if_id(s_flush_if_id),
        .freeze_back(s_freeze_back),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .memwait_cnt(s_memwait_cnt),
        .mem_timeout(s_mem_timeout), .hazard_err(s_hazard_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ctl bit order: {freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back}
    task automatic drive(input logic h, input logic b, input logic m, input logic c);
        hazard_detected = h;
        branch_taken    = b;
        mem_busy        = m;
        cnt_clr         = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        chk("rst_ctl", 32'(ctl), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_flags", 32'({mem_timeout, hazard_err}), 32'h0);
        drive(1, 1, 1, 0);
        chk("rst_ctl_gated", 32'(ctl), 32'h0);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Single-cycle load-use hazard
        drive(1, 0, 0, 0);
        chk("hz_ctl", 32'(ctl), 32'b11100);
        tick();
        drive(0, 0, 0, 0);
        chk("hz_ctl_next", 32'(ctl), 32'h0);
        chk("hz_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        chk("hz_err", 32'(hazard_err), 32'h0);

        // Branch overrides hazard
        do_reset();
        drive(1, 1, 0, 0);
        chk("br_ctl", 32'(ctl), 32'b00110);
        tick();
        drive(0, 0, 0, 0);
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // mem_busy 5 cycles with hazard pending, then hazard serviced
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0);
            chk($sformatf("mw_ctl%0d", i), 32'(ctl), 32'b11001);
            tick();
        end
        chk("mw_cnt", 32'(memwait_cnt), 32'd5);
        chk("mw_timeout", 32'(mem_timeout), 32'd1);
        drive(1, 0, 0, 0);
        chk("mw_release_ctl", 32'(ctl), 32'b11100);
        tick();
        drive(0, 0, 0, 0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        chk("mw_hz_err", 32'(hazard_err), 32'd0);

        // Timeout boundary at MEM_TIMEOUT=4, sticky after release
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(0, 0, 1, 0);
            tick();
            if (i == 3) chk("to_before", 32'(mem_timeout), 32'd0);
            if (i == 4) chk("to_at4", 32'(mem_timeout), 32'd1);
        end
        drive(0, 0, 0, 0);
        tick();
        chk("to_sticky", 32'(mem_timeout), 32'd1);

        // Back-to-back hazard sets hazard_err; clear priority over increment
        do_reset();
        drive(1, 0, 0, 0);
        tick();
        chk("hh_ctl2", 32'(ctl), 32'b11100);
        tick();
        chk("hh_err", 32'(hazard_err), 32'd1);
        chk("hh_stall_cnt", 32'(stall_cnt), 32'd2);
        drive(1, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("clr_err_kept", 32'(hazard_err), 32'd1);

        // Five flushes: wide counter counts, 2-bit counter saturates
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        chk("sat_flush_wide", 32'(flush_cnt), 32'd5);
        chk("sat_flush_2b", 32'(s_flush_cnt), 32'd3);

        // Asynchronous reset in the middle of a freeze
        drive(0, 0, 1, 0);
        chk("ar_ctl_frozen", 32'(ctl), 32'b11001);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ctl", 32'(ctl), 32'h0);
        chk("ar_cnts", 32'({flush_cnt, memwait_cnt}), 32'h0);
        chk("ar_cnt_2b", 32'(s_flush_cnt), 32'h0);
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
